// File: rtl/fifo_unpackager_if.sv
// fifo_unpackager_if: request/response bundle for the FIFO unpackager.
//   req_msg  : packed wide word from the FIFO read port (p_bit_width*p_num_concat bits)
//   req_val  : req_msg valid
//   req_rdy  : unpackager can accept a new wide word
//   resp_msg : current narrow slice (p_bit_width bits)
//   resp_val : resp_msg valid
//   resp_rdy : consumer accepts resp_msg
//   resp_last: last slice of the current word (only with FIFO_UNPACKAGER_LAST_EN)
// Modports: master = FIFO side / consumer driver, slave = unpackager.
interface fifo_unpackager_if #(
    parameter int unsigned p_bit_width  = 3,
    parameter int unsigned p_num_concat = 2
);
    localparam int unsigned p_full_bit_width = p_bit_width * p_num_concat;

    logic [p_full_bit_width-1:0] req_msg;
    logic                        req_val;
    logic                        req_rdy;
    logic [p_bit_width-1:0]      resp_msg;
    logic                        resp_val;
    logic                        resp_rdy;
`ifdef FIFO_UNPACKAGER_LAST_EN
    logic                        resp_last;

    modport master (
        output req_msg, req_val, resp_rdy,
        input  req_rdy, resp_msg, resp_val, resp_last
    );
    modport slave (
        input  req_msg, req_val, resp_rdy,
        output req_rdy, resp_msg, resp_val, resp_last
    );
`else
    modport master (
        output req_msg, req_val, resp_rdy,
        input  req_rdy, resp_msg, resp_val
    );
    modport slave (
        input  req_msg, req_val, resp_rdy,
        output req_rdy, resp_msg, resp_val
    );
`endif
endinterface

// File: rtl/fifo_unpackager.sv
// fifo_unpackager: accepts one wide word holding p_num_concat narrow messages packed
// MSB-first and emits them one slice per accepted cycle over a val/rdy interface.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : fifo_unpackager_if.slave (req_msg/req_val/req_rdy in, resp_msg/resp_val/resp_rdy out)
// Optional: define FIFO_UNPACKAGER_LAST_EN to drive bus.resp_last, high with the final
// slice of each word.
module fifo_unpackager #(
    parameter int unsigned p_bit_width  = 3,
    parameter int unsigned p_num_concat = 2
) (
    input  logic                clk,
    input  logic                reset,
    fifo_unpackager_if.slave    bus
);
    localparam int unsigned p_full_bit_width = p_bit_width * p_num_concat;
    localparam int unsigned CntW = (p_num_concat > 1) ? $clog2(p_num_concat) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(p_num_concat - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [p_full_bit_width-1:0] buf_q, buf_d;
    logic                        last_slice;
    logic                        resp_val;
    logic                        req_rdy;

    assign last_slice = (cnt_q == LastCnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_rdy = 1'b1;
                if (bus.req_val) begin
                    buf_d   = bus.req_msg;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                resp_val = 1'b1;
                if (bus.resp_rdy) begin
                    if (!last_slice) begin
                        buf_d = buf_q << p_bit_width;
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        // Last slice leaving: take the next word in the same cycle so a
                        // continuous stream has no bubble between words.
                        req_rdy = 1'b1;
                        if (bus.req_val) begin
                            buf_d = bus.req_msg;
                            cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_rdy  = req_rdy;
    assign bus.resp_val = resp_val;
    assign bus.resp_msg = buf_q[p_full_bit_width-1 -: p_bit_width];

`ifdef FIFO_UNPACKAGER_LAST_EN
    assign bus.resp_last = resp_val & last_slice;
`endif

endmodule
